// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, instruction-memory
// request handshake and the IF/ID pipeline register.
// The fetch address is held stable across memory wait states. A redirect that
// arrives during a wait is queued, and the stale word is dropped when it returns.
// Optional build macro IF_PERF_CNT_EN adds the perf_fetch_cnt and perf_wait_cnt
// counter outputs.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
  parameter logic [31:0] XADR_VECTOR  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_PC_Write,
  input  logic        IF_ID_Write,
  input  logic        IF_ID_Flush,
  input  logic [2:0]  ID_PCSrc,
  input  logic [31:0] ID_JumpTarget,
  input  logic [31:0] ID_JrTarget,
  input  logic [2:0]  EX_PCSrc,
  input  logic        EX_ALUOut0,
  input  logic [31:0] EX_BranchTarget,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  localparam logic [0:0] S_RUN   = 1'b0;  // normal fetching
  localparam logic [0:0] S_REDIR = 1'b1;  // stale request outstanding, redirect queued

  logic [0:0]  state;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic [31:0] redir_target;
  logic        redir_hit;
  logic        redir;
  logic        if_id_load;

  // Bit 31 is the supervisor bit. Only the lower 31 bits advance, so they wrap
  // within the current privilege half of the address space.
  assign pc_plus4  = {PC[31], PC[30:0] + 31'd4};
  assign imem_addr = PC;
  // A request is issued every cycle except while reset is held.
  assign imem_req  = reset;

  // Select the redirect target. A taken EX branch is older than the ID
  // instruction, so it has the highest priority.
  always_comb begin
    // NOTE: default every output of a combinational block first, so that no
    // path leaves it unassigned and infers a latch.
    redir_hit    = 1'b0;
    redir_target = '0;
    if (EX_PCSrc == 3'b001 && EX_ALUOut0) begin
      redir_hit    = 1'b1;
      redir_target = EX_BranchTarget;
    end else begin
      case (ID_PCSrc)
        3'b010:  begin redir_hit = 1'b1; redir_target = ID_JumpTarget; end
        3'b011:  begin redir_hit = 1'b1; redir_target = ID_JrTarget;   end
        3'b100:  begin redir_hit = 1'b1; redir_target = ILLOP_VECTOR;  end
        3'b101:  begin redir_hit = 1'b1; redir_target = XADR_VECTOR;   end
        default: begin redir_hit = 1'b0; redir_target = '0;            end
      endcase
    end
  end

  // A stalled pipeline blocks the redirect. The ID instruction is held and
  // presents the redirect again later.
  assign redir = redir_hit && IF_PC_Write;

  // A good word is latched only in S_RUN on a completed request.
  assign if_id_load = (state == S_RUN) && imem_ready;

  // Update the PC and the redirect FSM. The PC moves only when a request completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: use non-blocking assignments for all clocked state, so that every
      // register samples values from before the clock edge.
      PC          <= RESET_VECTOR;
      state       <= S_RUN;
      redirect_pc <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (imem_ready) begin
            if (redir)            PC <= redir_target;
            else if (IF_PC_Write) PC <= pc_plus4;
          end else if (redir) begin
            redirect_pc <= redir_target;
            state       <= S_REDIR;
          end
        end
        S_REDIR: begin
          if (redir) redirect_pc <= redir_target;
          if (imem_ready) begin
            PC    <= redir ? redir_target : redirect_pc;
            state <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Update the IF/ID register. A flush bubble overrides a hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IF_ID_Instr   <= '0;
      IF_ID_PCPlus4 <= '0;
      IF_ID_Valid   <= 1'b0;
    end else if (IF_ID_Flush) begin
      IF_ID_Instr   <= '0;
      IF_ID_PCPlus4 <= '0;
      IF_ID_Valid   <= 1'b0;
    end else if (IF_ID_Write) begin
      if (if_id_load) begin
        IF_ID_Instr   <= imem_rdata;
        IF_ID_PCPlus4 <= pc_plus4;
        IF_ID_Valid   <= 1'b1;
      end else begin
        IF_ID_Instr   <= '0;
        IF_ID_PCPlus4 <= '0;
        IF_ID_Valid   <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Count valid IF/ID loads and cycles spent waiting on instruction memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (!IF_ID_Flush && IF_ID_Write && if_id_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (imem_req && !imem_ready)                   perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage. The bench drives the instruction-memory
// responses directly, and every expected value is hand-computed.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        IF_PC_Write, IF_ID_Write, IF_ID_Flush;
  logic [2:0]  ID_PCSrc, EX_PCSrc;
  logic [31:0] ID_JumpTarget, ID_JrTarget, EX_BranchTarget;
  logic        EX_ALUOut0;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_req, imem_ready;
  logic [31:0] PC, IF_ID_Instr, IF_ID_PCPlus4;
  logic        IF_ID_Valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .reset(reset),
    .IF_PC_Write(IF_PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_PCSrc(ID_PCSrc), .ID_JumpTarget(ID_JumpTarget), .ID_JrTarget(ID_JrTarget),
    .EX_PCSrc(EX_PCSrc), .EX_ALUOut0(EX_ALUOut0), .EX_BranchTarget(EX_BranchTarget),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .PC(PC), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, then settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
  endtask

  initial begin
    reset = 1'b0;
    IF_PC_Write = 1'b1; IF_ID_Write = 1'b1; IF_ID_Flush = 1'b0;
    ID_PCSrc = 3'b000; ID_JumpTarget = '0; ID_JrTarget = '0;
    EX_PCSrc = 3'b000; EX_ALUOut0 = 1'b0; EX_BranchTarget = '0;
    imem_rdata = '0; imem_ready = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_pc", PC, 32'h8000_0000);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
    check("rst_instr", IF_ID_Instr, 32'd0);
    check("rst_pcp4", IF_ID_PCPlus4, 32'd0);
    reset = 1'b1;
    #1;
    check("req_on", {31'd0, imem_req}, 32'd1);
    check("addr0", imem_addr, 32'h8000_0000);

    // Sequential fetch
    fetch(32'h2408_0001);
    check("seq1_pc", PC, 32'h8000_0004);
    check("seq1_instr", IF_ID_Instr, 32'h2408_0001);
    check("seq1_pcp4", IF_ID_PCPlus4, 32'h8000_0004);
    check("seq1_valid", {31'd0, IF_ID_Valid}, 32'd1);
    fetch(32'h2409_0002);
    check("seq2_pc", PC, 32'h8000_0008);
    check("seq2_instr", IF_ID_Instr, 32'h2409_0002);
    check("seq2_pcp4", IF_ID_PCPlus4, 32'h8000_0008);
    fetch(32'h1111_1111);
    fetch(32'h2222_2222);
    check("seq4_pc", PC, 32'h8000_0010);

    // Three wait states at 0x80000010
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_addr", imem_addr, 32'h8000_0010);
      check("wait_bubble", {31'd0, IF_ID_Valid}, 32'd0);
    end
    fetch(32'h3333_3333);
    check("wait_done_pc", PC, 32'h8000_0014);
    check("wait_done_instr", IF_ID_Instr, 32'h3333_3333);
    check("wait_done_valid", {31'd0, IF_ID_Valid}, 32'd1);

    // Redirect arriving during a wait
    imem_ready = 1'b0; ID_PCSrc = 3'b010; ID_JumpTarget = 32'h0040_0020;
    step();
    check("rdw_hold_pc", PC, 32'h8000_0014);
    ID_PCSrc = 3'b000;
    step();
    check("rdw_hold_addr", imem_addr, 32'h8000_0014);
    fetch(32'hDEAD_BEEF);
    check("rdw_discard", {31'd0, IF_ID_Valid}, 32'd0);
    check("rdw_pc", PC, 32'h0040_0020);
    check("rdw_addr", imem_addr, 32'h0040_0020);
    fetch(32'h4444_4444);
    check("rdw_next_instr", IF_ID_Instr, 32'h4444_4444);
    check("rdw_next_pcp4", IF_ID_PCPlus4, 32'h0040_0024);
    check("rdw_next_pc", PC, 32'h0040_0024);

    // Newest queued redirect wins
    imem_ready = 1'b0; ID_PCSrc = 3'b010; ID_JumpTarget = 32'h0040_0040;
    step();
    ID_PCSrc = 3'b011; ID_JrTarget = 32'h0040_0080;
    step();
    ID_PCSrc = 3'b000;
    fetch(32'h0BAD_0BAD);
    check("newest_pc", PC, 32'h0040_0080);
    check("newest_discard", {31'd0, IF_ID_Valid}, 32'd0);

    // Redirect in the same cycle as ready while in S_REDIR (illegal-op vector)
    imem_ready = 1'b0; ID_PCSrc = 3'b010; ID_JumpTarget = 32'h0040_0040;
    step();
    ID_PCSrc = 3'b100;
    fetch(32'h0BAD_0BAD);
    check("illop_pc", PC, 32'h8000_0004);
    check("illop_discard", {31'd0, IF_ID_Valid}, 32'd0);

    // Priority: EX branch beats ID jr, and the flush forces a bubble
    EX_PCSrc = 3'b001; EX_ALUOut0 = 1'b1; EX_BranchTarget = 32'h0040_0100;
    ID_PCSrc = 3'b011; ID_JrTarget = 32'h0040_0200; IF_ID_Flush = 1'b1;
    fetch(32'h5A5A_5A5A);
    check("prio_pc", PC, 32'h0040_0100);
    check("prio_valid", {31'd0, IF_ID_Valid}, 32'd0);
    check("prio_instr", IF_ID_Instr, 32'd0);
    ID_PCSrc = 3'b000; IF_ID_Flush = 1'b0; EX_ALUOut0 = 1'b0;

    // Branch not taken falls through to PC+4
    fetch(32'h5555_5555);
    check("ntaken_pc", PC, 32'h0040_0104);
    check("ntaken_pcp4", IF_ID_PCPlus4, 32'h0040_0104);
    EX_PCSrc = 3'b000;

    // Load-use stall: PC and IF/ID hold, and the jr redirect is blocked
    IF_PC_Write = 1'b0; IF_ID_Write = 1'b0; ID_PCSrc = 3'b011; ID_JrTarget = 32'h0040_0300;
    for (int i = 0; i < 2; i++) begin
      fetch(32'h6666_6666);
      check("stall_pc", PC, 32'h0040_0104);
      check("stall_instr", IF_ID_Instr, 32'h5555_5555);
      check("stall_valid", {31'd0, IF_ID_Valid}, 32'd1);
    end
    IF_PC_Write = 1'b1; IF_ID_Write = 1'b1;
    fetch(32'h6666_6666);
    check("unstall_pc", PC, 32'h0040_0300);
    check("unstall_instr", IF_ID_Instr, 32'h6666_6666);
    check("unstall_pcp4", IF_ID_PCPlus4, 32'h0040_0108);
    ID_PCSrc = 3'b000;

    // A flush overrides an IF/ID hold
    IF_ID_Write = 1'b0; IF_ID_Flush = 1'b1;
    imem_ready = 1'b0;
    step();
    check("flush_hold_valid", {31'd0, IF_ID_Valid}, 32'd0);
    check("flush_hold_pcp4", IF_ID_PCPlus4, 32'd0);
    IF_ID_Write = 1'b1; IF_ID_Flush = 1'b0;

    // PC wrap: bit 31 is kept and the lower 31 bits wrap
    ID_PCSrc = 3'b010; ID_JumpTarget = 32'hFFFF_FFFC;
    fetch(32'h7070_7070);
    check("wrap_jump_pc", PC, 32'hFFFF_FFFC);
    ID_PCSrc = 3'b000;
    fetch(32'h7171_7171);
    check("wrap_pc", PC, 32'h8000_0000);
    check("wrap_pcp4", IF_ID_PCPlus4, 32'h8000_0000);

    // Exception vector
    ID_PCSrc = 3'b101;
    fetch(32'h7272_7272);
    check("xadr_pc", PC, 32'h8000_0008);
    ID_PCSrc = 3'b000;

`ifdef IF_PERF_CNT_EN
    // There were 9 not-ready cycles out of reset: 3 + 2 + 2 + 1 + 1 (flush test).
    check("perf_wait", perf_wait_cnt, 32'd9);
    check("perf_fetch", perf_fetch_cnt, 32'd11);
`endif

    // Reset in the middle of a wait drops the queued redirect
    imem_ready = 1'b0; ID_PCSrc = 3'b010; ID_JumpTarget = 32'h0040_0500;
    step();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_pc", PC, 32'h8000_0000);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    step();
    reset = 1'b1; ID_PCSrc = 3'b000;
    fetch(32'h7777_7777);
    check("postrst_valid", {31'd0, IF_ID_Valid}, 32'd1);
    check("postrst_instr", IF_ID_Instr, 32'h7777_7777);
    check("postrst_pc", PC, 32'h8000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: PC register, next-PC selection, instruction-memory request handshake, and the IF/ID pipeline register.
- Consumes the hazard unit's IF_PC_Write, IF_ID_Write and IF_ID_Flush, plus redirect information from ID (jump, jr, illegal-op, exception) and EX (taken branch).
- Feeds the ID stage.
- Holds the memory address stable across instruction-memory wait states and queues any redirect that arrives during a wait.

Parameters:
- RESET_VECTOR, 32'h8000_0000, PC value after reset.
- ILLOP_VECTOR, 32'h8000_0004, target when ID_PCSrc = 3'b100.
- XADR_VECTOR, 32'h8000_0008, target when ID_PCSrc = 3'b101.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IF_PC_Write  in  1  PC update enable from the hazard unit.
- IF_ID_Write  in  1  IF/ID load enable from the hazard unit.
- IF_ID_Flush  in  1  IF/ID bubble request from the hazard unit.
- ID_PCSrc  in  3  ID control: 010 J, 011 jr, 100 illop, 101 exception, other values mean none.
- ID_JumpTarget  in  32  J target computed in ID.
- ID_JrTarget  in  32  jr register value.
- EX_PCSrc  in  3  EX control: 001 means branch.
- EX_ALUOut0  in  1  branch condition true.
- EX_BranchTarget  in  32  branch target.
- imem_addr  out  32  fetch address.
- imem_req  out  1  fetch request.
- imem_rdata  in  32  instruction word.
- imem_ready  in  1  imem_rdata valid this cycle; the request completes.
- PC  out  32  current PC register.
- IF_ID_Instr  out  32  latched instruction.
- IF_ID_PCPlus4  out  32  latched PC+4.
- IF_ID_Valid  out  1  latched instruction is real, not a bubble.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - PC=RESET_VECTOR, state=S_RUN, redirect_pc=0.
  - IF_ID_Instr=0, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - imem_req=0 while reset is asserted; otherwise imem_req=1 every cycle.
  - imem_addr = PC, combinational.
- **PC+4** = {PC[31], PC[30:0]+31'd4}. Bit 31 (supervisor) is preserved; the lower 31 bits wrap modulo 2^31.
- **Redirect target**, highest priority first:
  1. EX_PCSrc==001 && EX_ALUOut0 → EX_BranchTarget.
  2. ID_PCSrc 010 → ID_JumpTarget.
  3. ID_PCSrc 011 → ID_JrTarget.
  4. ID_PCSrc 100 → ILLOP_VECTOR.
  5. ID_PCSrc 101 → XADR_VECTOR.
  - Otherwise there is no redirect. redir = (any of the above) && IF_PC_Write.
- **FSM state S_RUN:**
  - imem_ready=1:
    - if redir, PC ← target;
    - else if IF_PC_Write, PC ← PC+4;
    - else PC holds.
  - imem_ready=0: PC holds so imem_addr stays stable. If redir, redirect_pc ← target and go to S_REDIR.
- **FSM state S_REDIR** (a stale request is outstanding):
  - The instruction returned from imem is always discarded.
  - A new redir overwrites redirect_pc; the newest redirect wins.
  - imem_ready=1: PC ← redirect_pc (or the new target if redir is asserted this cycle), go to S_RUN.
  - imem_ready=0: stay in S_REDIR.
- **IF/ID register update**, evaluated in order:
  1. IF_ID_Flush=1 → bubble (Instr=0, PCPlus4=0, Valid=0). Flush overrides IF_ID_Write=0.
  2. Else IF_ID_Write=0 → hold.
  3. Else if S_RUN && imem_ready → Instr=imem_rdata, PCPlus4=PC+4, Valid=1.
  4. Else → bubble (wait state or discarded stale word).
- **Same-cycle rules:**
  - IF_PC_Write=0 blocks a redirect; the redirecting ID instruction is still held in ID and re-presents the redirect later.
  - An EX branch and an ID jump in the same cycle: the branch wins.
- Reset mid-wait aborts the request; there is no pending redirect after reset.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- **Defined:** adds outputs perf_fetch_cnt (32-bit) and perf_wait_cnt (32-bit).
  - perf_fetch_cnt increments on each IF/ID load with Valid=1.
  - perf_wait_cnt increments on each cycle with imem_req && !imem_ready.
  - Both reset to 0 and wrap at 2^32.
- **Undefined:** these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- **Reset, then sequential fetch:** reset released, imem_ready=1 with words 0x2408_0001 and 0x2409_0002 → PC 0x80000000→0x80000004→0x80000008. IF_ID_Instr gets each word with Valid=1. IF_ID_PCPlus4 = 0x80000004, then 0x80000008.
- **Wait state:** imem_ready=0 for 3 cycles at PC=0x80000010 → imem_addr stays 0x80000010; IF/ID receives bubbles. On ready the word is latched and PC becomes 0x80000014.
- **Redirect during wait:** ID_PCSrc=010, ID_JumpTarget=0x00400020 while imem_ready=0 → state S_REDIR. When ready, the word is discarded (Valid=0) and PC becomes 0x00400020; the next fetch is from 0x00400020.
- **Priority:** EX_PCSrc=001, EX_ALUOut0=1, EX_BranchTarget=0x00400100 together with ID_PCSrc=011, ID_JrTarget=0x00400200, IF_ID_Flush=1 → PC becomes 0x00400100 and IF/ID is a bubble.
- **Load-use stall:** IF_PC_Write=0, IF_ID_Write=0, ID_PCSrc=011 → PC and IF/ID hold. Once both return to 1, PC becomes ID_JrTarget.
- **PC wrap and exception:** PC=0xFFFFFFFC → next PC 0x80000000 (bit 31 kept). Separately, ID_PCSrc=101 → PC becomes 0x80000008. With IF_PERF_CNT_EN defined, perf_wait_cnt equals the count of not-ready cycles.
